// File: rtl/store_merge_unit.sv
// Store merge unit: places byte/half/word stores into little-endian lanes of a 32-bit word.
// Optional `STORE_MERGE_BYTE_ENABLE_EN replaces read-modify-write with lane byte enables (mem_be).
module store_merge_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_data,
  input  logic [1:0]        req_size,
  output logic              done,
  output logic              misalign,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_rvalid,
  output logic              mem_wr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack
`ifdef STORE_MERGE_BYTE_ENABLE_EN
  ,
  output logic [3:0]        mem_be
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WRITE,
    DONE,
    ERR
  } state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              bad;
  logic              accept;

  assign accept = (state == IDLE) && req_valid;
  assign bad    = (req_size == 2'b11) ||
                  ((req_size == 2'b01) && req_addr[0]) ||
                  ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));

`ifdef STORE_MERGE_BYTE_ENABLE_EN
  logic [3:0] be_q;
  logic       unused_rdata;
  assign unused_rdata = ^mem_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else if (accept) begin
      addr_q <= {req_addr[ADDR_W-1:2], 2'b00};
      case (req_size)
        2'b00: begin
          wdata_q <= {4{req_data[7:0]}};
          be_q    <= 4'b0001 << req_addr[1:0];
        end
        2'b01: begin
          wdata_q <= {2{req_data[15:0]}};
          be_q    <= req_addr[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          wdata_q <= req_data;
          be_q    <= 4'b1111;
        end
      endcase
    end
  end

  assign mem_be = be_q;
`else
  logic [15:0] data_q;
  logic [1:0]  lane_q;
  logic        half_q;
  logic [31:0] merged;

  // Only the addressed lane(s) come from the store; the rest preserve memory contents.
  always_comb begin
    merged = mem_rdata;
    if (half_q) begin
      if (lane_q[1]) merged[31:16] = data_q;
      else           merged[15:0]  = data_q;
    end else begin
      merged[{lane_q, 3'b000} +: 8] = data_q[7:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      lane_q  <= '0;
      half_q  <= 1'b0;
    end else if (accept) begin
      addr_q  <= {req_addr[ADDR_W-1:2], 2'b00};
      wdata_q <= req_data;
      data_q  <= req_data[15:0];
      lane_q  <= req_addr[1:0];
      half_q  <= (req_size == 2'b01);
    end else if ((state == READ) && mem_rvalid) begin
      wdata_q <= merged;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (bad)                     state_next = ERR;
          else if (req_size == 2'b10)  state_next = WRITE;
`ifdef STORE_MERGE_BYTE_ENABLE_EN
          else                         state_next = WRITE;
`else
          else                         state_next = READ;
`endif
        end
      end
      READ:    if (mem_rvalid) state_next = WRITE;
      WRITE:   if (mem_ack)    state_next = DONE;
      DONE:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strobes decode straight from state so an asynchronous reset drops them immediately.
  assign req_ready = (state == IDLE);
  assign mem_rd    = (state == READ);
  assign mem_wr    = (state == WRITE);
  assign done      = (state == DONE);
  assign misalign  = (state == ERR);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_store_merge_unit.sv
// Directed self-checking bench for store_merge_unit; honours `STORE_MERGE_BYTE_ENABLE_EN.
module tb_store_merge_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_size;
  logic        done;
  logic        misalign;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
`ifdef STORE_MERGE_BYTE_ENABLE_EN
  logic [3:0]  mem_be;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  int rd_cnt, wr_cnt, first_rd, first_wr, done_cnt, done_cyc;
  int mis_cnt, mis_cyc, overlap, unstable, ready_cyc;
  logic [31:0] rd_addr, wr_addr, wr_data;
  logic [3:0]  wr_be;

  always #5 clk = ~clk;

  store_merge_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
    .done(done), .misalign(misalign),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_ack(mem_ack)
`ifdef STORE_MERGE_BYTE_ENABLE_EN
    , .mem_be(mem_be)
`endif
  );

  // Issue one request and act as memory: rvalid after rdw extra read cycles, ack after ackw.
  task automatic run_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                           input int rdw, input int ackw);
    rd_cnt = 0; wr_cnt = 0; first_rd = 0; first_wr = 0; done_cnt = 0; done_cyc = 0;
    mis_cnt = 0; mis_cyc = 0; overlap = 0; unstable = 0; ready_cyc = 0;
    rd_addr = '0; wr_addr = '0; wr_data = '0; wr_be = '0;
    @(negedge clk);
    req_addr = a; req_data = d; req_size = s; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (c > 1) @(negedge clk);
      if (mem_rd) begin
        rd_cnt++;
        if (first_rd == 0) begin first_rd = c; rd_addr = mem_addr; end
        else if (mem_addr !== rd_addr) unstable++;
      end
      if (mem_wr) begin
        wr_cnt++;
        if (first_wr == 0) begin
          first_wr = c; wr_addr = mem_addr; wr_data = mem_wdata;
`ifdef STORE_MERGE_BYTE_ENABLE_EN
          wr_be = mem_be;
`endif
        end else if (mem_addr !== wr_addr || mem_wdata !== wr_data) unstable++;
      end
      if (mem_rd && mem_wr) overlap++;
      if (done) begin done_cnt++; done_cyc = c; end
      if (misalign) begin mis_cnt++; mis_cyc = c; end
      if (req_ready && c > 1) begin ready_cyc = c; break; end
      mem_rvalid = mem_rd && (rd_cnt > rdw);
      mem_ack    = mem_wr && (wr_cnt > ackw);
    end
    mem_rvalid = 1'b0;
    mem_ack    = 1'b0;
  endtask

  task automatic test_reset;
    n_checks++;
    if ({req_ready, done, misalign, mem_rd, mem_wr} !== 5'b10000) begin
      $display("FAIL reset_flags got %b exp 10000", {req_ready, done, misalign, mem_rd, mem_wr});
      n_fail++;
    end
    n_checks++;
    if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      $display("FAIL reset_bus got addr=%h wdata=%h exp 0/0", mem_addr, mem_wdata);
      n_fail++;
    end
  endtask

  task automatic test_word;
    run_store(32'h10, 32'hDEADBEEF, 2'b10, 0, 0);
    n_checks++;
    if (first_wr !== 1 || wr_addr !== 32'h10 || wr_data !== 32'hDEADBEEF) begin
      $display("FAIL sw_write got cyc=%0d addr=%h data=%h exp 1/00000010/deadbeef",
               first_wr, wr_addr, wr_data);
      n_fail++;
    end
    n_checks++;
    if (done_cyc !== 2 || done_cnt !== 1 || rd_cnt !== 0 || ready_cyc !== 3) begin
      $display("FAIL sw_timing got done=%0d cnt=%0d rd=%0d ready=%0d exp 2/1/0/3",
               done_cyc, done_cnt, rd_cnt, ready_cyc);
      n_fail++;
    end
`ifdef STORE_MERGE_BYTE_ENABLE_EN
    n_checks++;
    if (wr_be !== 4'b1111) begin
      $display("FAIL sw_be got %b exp 1111", wr_be); n_fail++;
    end
`endif
  endtask

  task automatic test_byte;
    mem_rdata = 32'h11223344;
    run_store(32'h13, 32'h000000AA, 2'b00, 0, 0);
`ifdef STORE_MERGE_BYTE_ENABLE_EN
    n_checks++;
    if (rd_cnt !== 0 || first_wr !== 1 || wr_data !== 32'hAAAAAAAA || wr_be !== 4'b1000
        || done_cyc !== 2 || done_cnt !== 1) begin
      $display("FAIL sb_lane3 got rd=%0d wr=%0d data=%h be=%b done=%0d/%0d exp 0/1/aaaaaaaa/1000/2/1",
               rd_cnt, first_wr, wr_data, wr_be, done_cyc, done_cnt);
      n_fail++;
    end
    run_store(32'h02, 32'h0000005A, 2'b00, 0, 0);
    n_checks++;
    if (rd_cnt !== 0 || wr_data !== 32'h5A5A5A5A || wr_be !== 4'b0100 || done_cyc !== 2) begin
      $display("FAIL sb_be_lane2 got rd=%0d data=%h be=%b done=%0d exp 0/5a5a5a5a/0100/2",
               rd_cnt, wr_data, wr_be, done_cyc);
      n_fail++;
    end
`else
    n_checks++;
    if (first_rd !== 1 || rd_addr !== 32'h10 || first_wr !== 2 || overlap !== 0) begin
      $display("FAIL sb_seq got rd=%0d raddr=%h wr=%0d overlap=%0d exp 1/00000010/2/0",
               first_rd, rd_addr, first_wr, overlap);
      n_fail++;
    end
    n_checks++;
    if (wr_data !== 32'hAA223344 || wr_addr !== 32'h10 || done_cyc !== 3 || done_cnt !== 1) begin
      $display("FAIL sb_lane3 got data=%h addr=%h done=%0d/%0d exp aa223344/00000010/3/1",
               wr_data, wr_addr, done_cyc, done_cnt);
      n_fail++;
    end
    run_store(32'h05, 32'hFFFFFF77, 2'b00, 0, 0);
    n_checks++;
    if (wr_data !== 32'h11227744 || wr_addr !== 32'h04) begin
      $display("FAIL sb_lane1 got data=%h addr=%h exp 11227744/00000004", wr_data, wr_addr);
      n_fail++;
    end
`endif
  endtask

  task automatic test_half;
    mem_rdata = 32'h11223344;
    run_store(32'h22, 32'h0000BEEF, 2'b01, 3, 0);
`ifdef STORE_MERGE_BYTE_ENABLE_EN
    n_checks++;
    if (rd_cnt !== 0 || wr_data !== 32'hBEEFBEEF || wr_be !== 4'b1100 || done_cyc !== 2
        || ready_cyc !== 3) begin
      $display("FAIL sh_upper got rd=%0d data=%h be=%b done=%0d ready=%0d exp 0/beefbeef/1100/2/3",
               rd_cnt, wr_data, wr_be, done_cyc, ready_cyc);
      n_fail++;
    end
    run_store(32'h20, 32'h0000CAFE, 2'b01, 0, 0);
    n_checks++;
    if (wr_data !== 32'hCAFECAFE || wr_be !== 4'b0011) begin
      $display("FAIL sh_lower got data=%h be=%b exp cafecafe/0011", wr_data, wr_be);
      n_fail++;
    end
`else
    n_checks++;
    if (rd_cnt !== 4 || rd_addr !== 32'h20 || unstable !== 0 || first_wr !== 5) begin
      $display("FAIL sh_wait_read got rd=%0d raddr=%h unstable=%0d wr=%0d exp 4/00000020/0/5",
               rd_cnt, rd_addr, unstable, first_wr);
      n_fail++;
    end
    n_checks++;
    if (wr_data !== 32'hBEEF3344 || done_cyc !== 6 || ready_cyc !== 7 || done_cnt !== 1) begin
      $display("FAIL sh_upper got data=%h done=%0d ready=%0d cnt=%0d exp beef3344/6/7/1",
               wr_data, done_cyc, ready_cyc, done_cnt);
      n_fail++;
    end
    run_store(32'h20, 32'h0000CAFE, 2'b01, 0, 0);
    n_checks++;
    if (wr_data !== 32'h1122CAFE || done_cyc !== 3) begin
      $display("FAIL sh_lower got data=%h done=%0d exp 1122cafe/3", wr_data, done_cyc);
      n_fail++;
    end
`endif
  endtask

  task automatic test_misalign;
    logic [31:0] addrs [3];
    logic [1:0]  sizes [3];
    addrs[0] = 32'h21; sizes[0] = 2'b01;
    addrs[1] = 32'h06; sizes[1] = 2'b10;
    addrs[2] = 32'h00; sizes[2] = 2'b11;
    for (int i = 0; i < 3; i++) begin
      run_store(addrs[i], 32'h12345678, sizes[i], 0, 0);
      n_checks++;
      if (mis_cnt !== 1 || mis_cyc !== 1 || rd_cnt + wr_cnt !== 0 || done_cnt !== 0
          || ready_cyc !== 2) begin
        $display("FAIL misalign_%0d got mis=%0d@%0d strobes=%0d done=%0d ready=%0d exp 1@1/0/0/2",
                 i, mis_cnt, mis_cyc, rd_cnt + wr_cnt, done_cnt, ready_cyc);
        n_fail++;
      end
    end
  endtask

  task automatic test_spurious;
    @(negedge clk);
    mem_ack = 1'b1; mem_rvalid = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({req_ready, done, misalign, mem_rd, mem_wr} !== 5'b10000) begin
      $display("FAIL spurious_ack got %b exp 10000", {req_ready, done, misalign, mem_rd, mem_wr});
      n_fail++;
    end
    mem_ack = 1'b0; mem_rvalid = 1'b0;
  endtask

  task automatic test_reset_mid;
    int wc;
    int dc;
    wc = 0; dc = 0;
    mem_rdata = 32'h11223344;
    @(negedge clk);
    req_addr = 32'h0; req_data = 32'h000000AA; req_size = 2'b00; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 0; c < 20 && wc < 2; c++) begin
      if (c > 0) @(negedge clk);
      if (mem_wr) wc++;
      if (done) dc++;
      mem_rvalid = mem_rd;
      mem_ack = 1'b0;
    end
    mem_rvalid = 1'b0;
    n_checks++;
    if (wc !== 2) begin
      $display("FAIL rst_mid_reach_write got wr_cycles=%0d exp 2", wc); n_fail++;
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({req_ready, mem_wr, mem_rd, done} !== 4'b1000 || mem_addr !== 32'h0) begin
      $display("FAIL rst_mid_async got rdy/wr/rd/done=%b addr=%h exp 1000/00000000",
               {req_ready, mem_wr, mem_rd, done}, mem_addr);
      n_fail++;
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done) dc++;
    end
    n_checks++;
    if (dc !== 0 || req_ready !== 1'b1) begin
      $display("FAIL rst_mid_nodone got done=%0d ready=%b exp 0/1", dc, req_ready);
      n_fail++;
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_data = '0; req_size = '0;
    mem_rdata = '0; mem_rvalid = 1'b0; mem_ack = 1'b0;
    #3;
    test_reset;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_word;
    test_byte;
    test_half;
    test_misalign;
    test_spurious;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/store_merge_unit.md
Name: store_merge_unit

Overview:
- Store-side counterpart of the load extension path.
- Takes a byte, halfword or word store from the CPU datapath and places the data in the correct little-endian lane of a 32-bit word.
- Sub-word stores use a read-modify-write sequence on the word-wide data memory; word stores write directly.
- Sits between the datapath store port and the data-memory interface, using valid/ready on the CPU side and request/ack on the memory side.

Parameters:
- ADDR_W, 32, byte-address width; memory addresses are word-aligned (addr[1:0] forced to 0).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  store request present
- req_ready  out  1  unit can accept a request (high only in IDLE)
- req_addr  in  ADDR_W  byte address of store
- req_data  in  32  store data, right-justified (byte in [7:0], half in [15:0])
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- done  out  1  one-cycle pulse: store committed
- misalign  out  1  one-cycle pulse: request rejected, no memory access
- mem_addr  out  ADDR_W  word address, low 2 bits zero
- mem_rd  out  1  read strobe, held until mem_rvalid
- mem_rdata  in  32  read data
- mem_rvalid  in  1  read data valid (may arrive the same cycle as mem_rd or later)
- mem_wr  out  1  write strobe, held until mem_ack
- mem_wdata  out  32  write data
- mem_ack  in  1  write accepted

Behaviour:
- Reset values: state IDLE; req_ready=1; done=0; misalign=0; mem_rd=0; mem_wr=0; mem_addr=0; mem_wdata=0.
- A request is accepted on a rising edge when req_valid and req_ready are both high. On acceptance, addr, data, size and lane (addr[1:0]) are latched and req_ready drops the next cycle.
- Alignment check at acceptance:
  - size 01 with addr[0]=1 is misaligned.
  - size 10 with addr[1:0]≠00 is misaligned.
  - size 11 is always rejected.
  - On any of these, go to ERR: misalign pulses for one cycle, no mem strobe is asserted, then return to IDLE.
- States and transitions:
  - IDLE: accept; word goes to WRITE, byte/half goes to READ, error goes to ERR.
  - READ: mem_rd=1 and mem_addr={addr[ADDR_W-1:2],2'b00}. When mem_rvalid is sampled high, register the merged word and go to WRITE.
  - Merge rules:
    - byte: lane k = addr[1:0]; bits [8k+7:8k] are replaced by data[7:0], all other bits come from mem_rdata.
    - half: addr[1]=0 replaces [15:0]; addr[1]=1 replaces [31:16]; data taken from data[15:0].
  - WRITE: mem_wr=1 with mem_wdata = merged word (or req_data for word stores). When mem_ack is sampled high, go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
  - ERR: misalign=1 for one cycle, then IDLE.
- mem_rd and mem_wr are never high in the same cycle. mem_addr and mem_wdata are stable while a strobe is high.
- Minimum latency with zero-wait memory:
  - Word: accept at edge N, mem_wr high in cycle N+1, done high in cycle N+2.
  - Byte/half: mem_rd high in N+1, mem_wr high in N+2, done high in N+3.
- An ack or rvalid arriving while the unit is not waiting for it is ignored.
- Asserting rst mid-operation forces IDLE immediately. All strobes drop, no done pulse is issued, and the in-flight store is abandoned (the memory may have seen a partial read only, never a partial write).

Optional Feature:
- Macro: STORE_MERGE_BYTE_ENABLE_EN
- When defined:
  - Adds output port mem_be [3:0].
  - Sub-word stores skip READ and go straight to WRITE.
  - mem_wdata carries the data replicated: byte gives {4{data[7:0]}}, half gives {2{data[15:0]}}.
  - mem_be selects the lanes: byte gives 4'b0001<<addr[1:0]; half gives 4'b0011 or 4'b1100; word gives 4'b1111.
  - Byte/half latency becomes equal to word latency.
- When undefined: no mem_be port and the read-modify-write path described above is used. mem_rd is never asserted when the macro is defined.

Test Plan:
- SW addr=0x10, data=0xDEADBEEF, zero-wait memory -> mem_wr in cycle N+1 with mem_addr=0x10 and mem_wdata=0xDEADBEEF; done in N+2; mem_rd never high.
- SB addr=0x13, data=0x000000AA, mem_rdata=0x11223344 -> mem_rd then mem_wr; mem_wdata=0xAA223344; done once.
- SH addr=0x22, data=0x0000BEEF, mem_rdata=0x11223344, mem_rvalid delayed 3 cycles -> mem_rd held 4 cycles; mem_wdata=0xBEEF3344; req_ready low throughout.
- SH addr=0x21, then SW addr=0x06, then size=11 -> three misalign pulses, zero mem strobes, req_ready back high after each.
- SB addr=0x00 with mem_ack held low 5 cycles, rst pulsed during WRITE -> mem_wr drops asynchronously, state IDLE, req_ready=1, no done.
- With STORE_MERGE_BYTE_ENABLE_EN: SB addr=0x02, data=0x5A -> no read; mem_be=0100; mem_wdata=0x5A5A5A5A; done in N+2.
